// File: rtl/subkey_gen_if.sv
// Round-key byte stream plus shared S-box lookup between the key scheduler and its consumer.
interface subkey_gen_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         next_byte;
  logic [7:0]   subkey;
  logic         subkey_valid;
  logic [3:0]   round;
  logic         busy;
  logic         done;
  logic [7:0]   sbox_addr;
  logic [7:0]   sbox_data;

  // Consumer/environment side: loads keys, pulls bytes, answers S-box lookups.
  modport master (
    output key_load, key_in, next_byte, sbox_data,
    input  subkey, subkey_valid, round, busy, done, sbox_addr
  );

  modport slave (
    input  key_load, key_in, next_byte, sbox_data,
    output subkey, subkey_valid, round, busy, done, sbox_addr
  );
endinterface

// File: rtl/subkey_gen.sv
// AES round-key byte streamer: one byte per accepted next_byte, 5-cycle iterative expansion
// between rounds through a shared S-box; next_byte is ignored whenever subkey_valid is low.
module subkey_gen #(
  parameter int unsigned NROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  subkey_gen_if.slave kif
);

  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  typedef enum logic [1:0] {IDLE, READY, EXPAND, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  subw_q, subw_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   ecnt_q, ecnt_d;

  logic [7:0]   subkey_d;
  logic         subkey_valid_d;
  logic         busy_d;
  logic         done_d;
  logic [7:0]   sbox_addr_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, rot_sel;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] key_sh;
  logic [7:0]   rcon;

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Byte k of RotWord(w3) is brought to the top byte by shifting k bytes left.
  assign rot_w3  = {w3[23:0], w3[31:24]};
  assign rot_sel = rot_w3 << {ecnt_q[1:0], 3'b000};
  assign key_sh  = key_q << {idx_q, 3'b000};

  assign rcon = rcon_f(round_q + 4'd1);
  assign nw0  = w0 ^ subw_q ^ {rcon, 24'h000000};
  assign nw1  = w1 ^ nw0;
  assign nw2  = w2 ^ nw1;
  assign nw3  = w3 ^ nw2;

  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    subw_d         = subw_q;
    idx_d          = idx_q;
    round_d        = round_q;
    ecnt_d         = ecnt_q;
    subkey_d       = 8'h00;
    subkey_valid_d = 1'b0;
    busy_d         = 1'b0;
    done_d         = 1'b0;
    sbox_addr_d    = 8'h00;

    unique case (state_q)
      IDLE: begin
      end

      READY: begin
        subkey_valid_d = 1'b1;
        subkey_d       = key_sh[127:120];
        if (kif.next_byte) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            if (round_q == LAST_ROUND) begin
              state_d = DONE;
            end else begin
              state_d = EXPAND;
              ecnt_d  = 3'd0;
            end
          end
        end
      end

      EXPAND: begin
        busy_d = 1'b1;
        if (ecnt_q == 3'd4) begin
          key_d   = {nw0, nw1, nw2, nw3};
          round_d = round_q + 4'd1;
          idx_d   = 4'd0;
          ecnt_d  = 3'd0;
          state_d = READY;
        end else begin
          sbox_addr_d = rot_sel[31:24];
          ecnt_d      = ecnt_q + 3'd1;
          case (ecnt_q[1:0])
            2'd0:    subw_d[31:24] = kif.sbox_data;
            2'd1:    subw_d[23:16] = kif.sbox_data;
            2'd2:    subw_d[15:8]  = kif.sbox_data;
            default: subw_d[7:0]   = kif.sbox_data;
          endcase
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // A fresh key wins over whatever the current state was doing.
    if (kif.key_load) begin
      key_d   = kif.key_in;
      idx_d   = 4'd0;
      round_d = 4'd0;
      ecnt_d  = 3'd0;
      state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      subw_q  <= '0;
      idx_q   <= '0;
      round_q <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      subw_q  <= subw_d;
      idx_q   <= idx_d;
      round_q <= round_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign kif.subkey       = subkey_d;
  assign kif.subkey_valid = subkey_valid_d;
  assign kif.busy         = busy_d;
  assign kif.done         = done_d;
  assign kif.sbox_addr    = sbox_addr_d;
  assign kif.round        = round_q;

endmodule

// File: tb/tb_subkey_gen.sv
// Self-checking bench for subkey_gen: AES-128 key expansion reference model, GF(2^8)-derived S-box.
module tb_subkey_gen;
  localparam int NR = 10;
  localparam int NB = 16 * (NR + 1);

  logic clk = 1'b0;
  logic rst;

  subkey_gen_if kif();

  subkey_gen #(.NROUNDS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  sbox_tab  [256];
  logic [7:0]  exp_bytes [NB];
  logic [31:0] exp_rot   [NR];
  logic [7:0]  obs_bytes [NB];
  logic [31:0] obs_rot0;

  assign kif.sbox_data = sbox_tab[kif.sbox_addr];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_val(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    if (x == 8'h00) inv = 8'h00;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] obs_round(input int r);
    logic [127:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v = {v[119:0], obs_bytes[16*r+b]};
    return v;
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        exp_rot[i/4-1] = {t[23:0], t[31:24]};
        t = sub_word(exp_rot[i/4-1]) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 4*(NR+1); i++)
      for (int j = 0; j < 4; j++) exp_bytes[4*i+j] = w[i][31-8*j -: 8];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".subkey"},       kif.subkey,       8'h00);
    chk({tag, ".subkey_valid"}, kif.subkey_valid, 1'b0);
    chk({tag, ".round"},        kif.round,        4'd0);
    chk({tag, ".busy"},         kif.busy,         1'b0);
    chk({tag, ".done"},         kif.done,         1'b0);
    chk({tag, ".sbox_addr"},    kif.sbox_addr,    8'h00);
  endtask

  task automatic load(input logic [127:0] k);
    build_model(k);
    kif.key_load  = 1'b1;
    kif.key_in    = k;
    kif.next_byte = 1'($urandom);
    step();
    kif.key_load  = 1'b0;
    kif.key_in    = rand128();
  endtask

  // Walk the expected byte stream; pct is the chance per cycle of asserting next_byte.
  // Stops (without stepping) at byte stop_b of round stop_r, or at expansion cycle stop_k after round stop_r.
  task automatic play(input int stop_r, input int stop_b, input int stop_k, input int pct);
    int  waited;
    bit  acc;
    for (int r = 0; r <= NR; r++) begin
      for (int b = 0; b < 16; b++) begin
        if (r == stop_r && b == stop_b) return;
        waited = 0;
        acc = 1'b0;
        while (!acc) begin
          chk("ready.valid",     kif.subkey_valid, 1'b1);
          chk("ready.subkey",    kif.subkey,       exp_bytes[16*r+b]);
          chk("ready.round",     kif.round,        r);
          chk("ready.busy",      kif.busy,         1'b0);
          chk("ready.sbox_addr", kif.sbox_addr,    8'h00);
          acc = (int'($urandom_range(99)) < pct) || (waited >= 20);
          kif.next_byte = acc;
          obs_bytes[16*r+b] = kif.subkey;
          step();
          waited++;
        end
      end
      if (r < NR) begin
        for (int k = 0; k < 5; k++) begin
          chk("exp.busy",   kif.busy,         1'b1);
          chk("exp.valid",  kif.subkey_valid, 1'b0);
          chk("exp.subkey", kif.subkey,       8'h00);
          chk("exp.round",  kif.round,        r);
          chk("exp.done",   kif.done,         1'b0);
          chk("exp.sbox_addr", kif.sbox_addr, (k < 4) ? exp_rot[r][31-8*k -: 8] : 8'h00);
          if (r == 0 && k < 4) obs_rot0[31-8*k -: 8] = kif.sbox_addr;
          if (r == stop_r && k == stop_k) return;
          kif.next_byte = 1'($urandom);
          step();
        end
      end else begin
        chk("done.pulse",  kif.done,         1'b1);
        chk("done.valid",  kif.subkey_valid, 1'b0);
        chk("done.busy",   kif.busy,         1'b0);
        chk("done.subkey", kif.subkey,       8'h00);
        chk("done.round",  kif.round,        NR);
        for (int c = 0; c < 3; c++) begin
          kif.next_byte = 1'($urandom);
          step();
          chk("post.done",  kif.done,         1'b0);
          chk("post.valid", kif.subkey_valid, 1'b0);
          chk("post.round", kif.round,        NR);
          chk("post.busy",  kif.busy,         1'b0);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k1;
    logic [127:0] k2;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_val(8'(i));
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    rst           = 1'b1;
    kif.key_load  = 1'b0;
    kif.key_in    = '0;
    kif.next_byte = 1'b0;
    for (int c = 0; c < 2; c++) begin
      kif.key_load  = 1'($urandom);
      kif.next_byte = 1'($urandom);
      kif.key_in    = rand128();
      step();
    end
    chk_idle("reset");
    rst          = 1'b0;
    kif.key_load = 1'b0;
    step();
    chk_idle("idle");

    // Known-answer schedule with next_byte held high.
    load(k1);
    play(-1, -1, -1, 100);
    chk("kat.round0", obs_round(0), k1);
    chk("kat.sbox_addr0", obs_rot0, 32'hcf4f3c09);
    chk("kat.round1", obs_round(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat.round10", obs_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Same key, next_byte toggled randomly including during expansion.
    load(k1);
    play(-1, -1, -1, 50);
    chk("toggle.round1", obs_round(1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("toggle.round10", obs_round(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // New key loaded in E2 of the expansion after round 3, with next_byte also high.
    load(k1);
    play(3, -1, 2, 60);
    k2 = rand128();
    build_model(k2);
    kif.key_load  = 1'b1;
    kif.key_in    = k2;
    kif.next_byte = 1'b1;
    step();
    kif.key_load = 1'b0;
    chk("reload.round",  kif.round,        4'd0);
    chk("reload.subkey", kif.subkey,       k2[127:120]);
    chk("reload.busy",   kif.busy,         1'b0);
    chk("reload.valid",  kif.subkey_valid, 1'b1);
    play(-1, -1, -1, 40);

    // Reset in round 5 at index 7, overriding a simultaneous key_load.
    load(rand128());
    play(5, 7, -1, 70);
    rst           = 1'b1;
    kif.key_load  = 1'b1;
    kif.key_in    = rand128();
    kif.next_byte = 1'b1;
    step();
    rst          = 1'b0;
    kif.key_load = 1'b0;
    chk_idle("midrst");
    for (int c = 0; c < 4; c++) begin
      kif.next_byte = 1'($urandom);
      step();
      chk_idle("midrst.hold");
    end
    load(rand128());
    play(-1, -1, -1, 80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
